// File: rtl/tracker_pkg.sv
// Shared types and helpers for the tracker query engine: query status codes,
// FSM states, the result record and window arithmetic.
package tracker_pkg;

  localparam int REC_TAG_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BADWIN  = 2'd3
  } query_status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_EMIT   = 3'd4
  } query_state_e;

  typedef struct packed {
    logic signed [31:0]       start_pt;
    logic signed [31:0]       end_pt;
    logic [REC_TAG_WIDTH-1:0] tag;
    query_status_e            status;
  } query_rec_t;

  // A window is usable when it fits inside the tracker history (1..depth).
  function automatic logic window_legal(input logic signed [31:0] win, input int depth);
    return (win >= 32'sd1) && (win <= depth);
  endfunction

  function automatic logic signed [31:0] grow_window(input logic signed [31:0] win, input int depth);
    logic signed [31:0] grown;
    if (win >= depth) begin
      grown = depth;
    end else begin
      grown = win + 32'sd1;
    end
    return grown;
  endfunction

endpackage

// File: rtl/tracker_req_fifo.sv
// Request FIFO holding {window, tag}; wrap-bit pointers with registered
// full/empty flags so req_ready never depends on a same-cycle pop.
module tracker_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic             full_r, empty_r;
  logic             push_ok_s, pop_ok_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign full      = full_r;
  assign empty     = empty_r;

  // Next pointer values.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    if (push_ok_s) begin
      wr_ptr_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (pop_ok_s) begin
      rd_ptr_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
  end

  // Pointers and flags; full when indices match but wrap bits differ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      full_r   <= (wr_ptr_s[AW] != rd_ptr_s[AW]) && (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
      empty_r  <= (wr_ptr_s == rd_ptr_s);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/tracker_query_engine.sv
// Sequences queued lookback queries into signal_tracker's timing-check port,
// retries unresolved intervals and returns one tagged record per query.
module tracker_query_engine
  import tracker_pkg::*;
#(
  parameter int BUFFER_WIDTH = 8,
  parameter int REQ_DEPTH    = 4,
  parameter int MAX_RETRIES  = 6,
  parameter int TAG_WIDTH    = REC_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           counter,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_window,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  recalculate_time,
  output logic [31:0]           value_in,
  input  logic [1:0][31:0]      time_out_i,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic signed [31:0]    res_start,
  output logic signed [31:0]    res_end,
  output logic [TAG_WIDTH-1:0]  res_tag,
  output logic [1:0]            res_status
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int FW = 32 + TAG_WIDTH;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  query_state_e          state_r, state_s;
  logic signed [31:0]    win_r, win_s;
  logic [TAG_WIDTH-1:0]  tag_r, tag_s;
  logic [RW-1:0]         retries_r, retries_s;
  logic                  badwin_r, badwin_s;
  logic signed [31:0]    cap_start_r, cap_start_s, cap_end_r, cap_end_s;
  query_rec_t            rec_r, rec_s;
  logic                  res_valid_r, res_valid_s;
  logic                  recalc_r, recalc_s;
  logic [31:0]           value_in_r, value_in_s;

  logic                  fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [FW-1:0]         fifo_head_s;
  logic signed [31:0]    head_win_s;
  logic [TAG_WIDTH-1:0]  head_tag_s;
  logic                  counter_unused_s;

  // The counter only feeds the tracker; nothing here does arithmetic on it.
  assign counter_unused_s = ^counter;

  tracker_req_fifo #(.DEPTH(REQ_DEPTH), .WIDTH(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data ({req_window, req_tag}),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign head_win_s       = $signed(fifo_head_s[FW-1:TAG_WIDTH]);
  assign head_tag_s       = fifo_head_s[TAG_WIDTH-1:0];
  assign req_ready        = !fifo_full_s;
  assign recalculate_time = recalc_r;
  assign value_in         = value_in_r;
  assign res_valid        = res_valid_r;
  assign res_start        = rec_r.start_pt;
  assign res_end          = rec_r.end_pt;
  assign res_tag          = rec_r.tag;
  assign res_status       = rec_r.status;

  // Next state plus next values of working and output registers.
  always_comb begin
    state_s     = state_r;
    win_s       = win_r;
    tag_s       = tag_r;
    retries_s   = retries_r;
    badwin_s    = badwin_r;
    cap_start_s = cap_start_r;
    cap_end_s   = cap_end_r;
    rec_s       = rec_r;
    res_valid_s = res_valid_r;
    recalc_s    = 1'b0;
    value_in_s  = value_in_r;
    fifo_pop_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          win_s      = head_win_s;
          tag_s      = head_tag_s;
          retries_s  = {RW{1'b0}};
          badwin_s   = !window_legal(head_win_s, BUFFER_WIDTH);
          // Out-of-range windows skip the tracker and resolve in SAMPLE.
          if (badwin_s) begin
            state_s = S_SAMPLE;
          end else begin
            state_s    = S_ISSUE;
            recalc_s   = 1'b1;
            value_in_s = head_win_s;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: state_s = S_WAIT;
      S_WAIT: begin
        cap_start_s = $signed(time_out_i[0]);
        cap_end_s   = $signed(time_out_i[1]);
        state_s     = S_SAMPLE;
      end
      S_SAMPLE: begin
        rec_s.start_pt = cap_start_r;
        rec_s.end_pt   = cap_end_r;
        rec_s.tag      = tag_r;
        rec_s.status   = ST_OK;
        res_valid_s    = 1'b1;
        state_s        = S_EMIT;
        if (badwin_r) begin
          rec_s.start_pt = -32'sd1;
          rec_s.end_pt   = -32'sd1;
          rec_s.status   = ST_BADWIN;
        end else if (!cap_start_r[31] && !cap_end_r[31]) begin
          rec_s.status = ST_OK;
        end else if (retries_r < RETRY_LIMIT) begin
          rec_s       = rec_r;
          res_valid_s = 1'b0;
          retries_s   = retries_r + RW'(1'b1);
          // A found start with a missing end means the window is too short.
          if (!cap_start_r[31]) begin
            win_s = grow_window(win_r, BUFFER_WIDTH);
          end else begin
            win_s = win_r;
          end
          state_s    = S_ISSUE;
          recalc_s   = 1'b1;
          value_in_s = win_s;
        end else if (!cap_start_r[31]) begin
          rec_s.status = ST_PARTIAL;
        end else begin
          rec_s.start_pt = -32'sd1;
          rec_s.end_pt   = -32'sd1;
          rec_s.status   = ST_TIMEOUT;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          res_valid_s = 1'b0;
          state_s     = S_IDLE;
        end else begin
          state_s = S_EMIT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r          <= 32'sd0;
      tag_r          <= {TAG_WIDTH{1'b0}};
      retries_r      <= {RW{1'b0}};
      badwin_r       <= 1'b0;
      cap_start_r    <= -32'sd1;
      cap_end_r      <= -32'sd1;
      rec_r.start_pt <= -32'sd1;
      rec_r.end_pt   <= -32'sd1;
      rec_r.tag      <= {TAG_WIDTH{1'b0}};
      rec_r.status   <= ST_OK;
      res_valid_r    <= 1'b0;
      recalc_r       <= 1'b0;
      value_in_r     <= 32'd0;
    end else begin
      win_r       <= win_s;
      tag_r       <= tag_s;
      retries_r   <= retries_s;
      badwin_r    <= badwin_s;
      cap_start_r <= cap_start_s;
      cap_end_r   <= cap_end_s;
      rec_r       <= rec_s;
      res_valid_r <= res_valid_s;
      recalc_r    <= recalc_s;
      value_in_r  <= value_in_s;
    end
  end

endmodule

// File: tb/tb_tracker_query_engine.sv
// Scoreboard bench for tracker_query_engine with a behavioural tracker model
// and a per-query reference computed from the retry rules.
module tb_tracker_query_engine;

  localparam int BW   = 8;
  localparam int DEP  = 4;
  localparam int MAXR = 6;
  localparam int TW   = 4;
  localparam int NRSP = 4096;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [31:0]          counter;
  logic                 req_valid, req_ready;
  logic [31:0]          req_window;
  logic [TW-1:0]        req_tag;
  logic                 recalculate_time;
  logic [31:0]          value_in;
  logic [1:0][31:0]     time_out_i;
  logic                 res_valid, res_ready;
  logic signed [31:0]   res_start, res_end;
  logic [TW-1:0]        res_tag;
  logic [1:0]           res_status;

  typedef struct {
    int s; int e; int tag; int st; int lat; int acc;
  } exp_t;

  int   rsp_s [NRSP];
  int   rsp_e [NRSP];
  int   model_pulse = 0;
  exp_t exp_q [$];
  int   vin_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   trk_idx = 0;
  int   trk_count = 0;
  int   rr_mode = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign counter = 32'(cyc);

  tracker_query_engine #(
    .BUFFER_WIDTH(BW), .REQ_DEPTH(DEP), .MAX_RETRIES(MAXR), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .counter(counter),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_window(req_window), .req_tag(req_tag),
    .recalculate_time(recalculate_time), .value_in(value_in),
    .time_out_i(time_out_i),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_start(res_start), .res_end(res_end),
    .res_tag(res_tag), .res_status(res_status)
  );

  task automatic check(input string name, input bit ok, input string got, input string want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  // Reference: walk the tracker answers for this query issue by issue.
  task automatic predict(input int w, input int tag, input bit lat_on, input int acc);
    exp_t x;
    int cur, a, b, k;
    bit done;
    x.tag = tag;
    x.acc = acc;
    if (w < 1 || w > BW) begin
      x.s = -1; x.e = -1; x.st = 3;
      x.lat = lat_on ? 2 : -1;
    end else begin
      cur = w; k = 0; done = 1'b0;
      while (!done) begin
        a = rsp_s[model_pulse % NRSP];
        b = rsp_e[model_pulse % NRSP];
        model_pulse++;
        vin_q.push_back(cur);
        if (a >= 0 && b >= 0) begin
          x.s = a; x.e = b; x.st = 0; done = 1'b1;
        end else if (k == MAXR) begin
          if (a >= 0) begin x.s = a; x.e = b; x.st = 1; end
          else begin x.s = -1; x.e = -1; x.st = 2; end
          done = 1'b1;
        end else begin
          if (a >= 0) cur = (cur + 1 > BW) ? BW : cur + 1;
          k++;
        end
      end
      x.lat = lat_on ? 4 + 3 * k : -1;
    end
    exp_q.push_back(x);
  endtask

  task automatic set_rsp(input int off, input int a, input int b);
    rsp_s[(model_pulse + off) % NRSP] = a;
    rsp_e[(model_pulse + off) % NRSP] = b;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input int w, input int tag, input bit lat_on);
    int n = 0;
    req_valid  = 1'b1;
    req_window = 32'(w);
    req_tag    = TW'(tag);
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("push_accept", 1'b0, "req_ready=0", "accept");
    else predict(w, tag, lat_on, cyc + 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string name);
    check(name,
          req_ready === 1'b1 && recalculate_time === 1'b0 && value_in === 32'd0 &&
          res_valid === 1'b0 && res_start === -32'sd1 && res_end === -32'sd1 &&
          res_tag === 4'd0 && res_status === 2'd0,
          $sformatf("rdy=%b rc=%b vin=%0d rv=%b s=%0d e=%0d tag=%0d st=%0d",
                    req_ready, recalculate_time, value_in, res_valid,
                    res_start, res_end, res_tag, res_status),
          "rdy=1 rc=0 vin=0 rv=0 s=-1 e=-1 tag=0 st=0");
  endtask

  // Consumer: drives res_ready according to the current mode.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Tracker model: answers each pulse from the response table.
  initial begin
    int v;
    time_out_i = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        vin_q.delete();
        trk_idx = model_pulse;
      end else if (recalculate_time) begin
        trk_count++;
        if (vin_q.size() == 0) begin
          check("pulse_expected", 1'b0, "extra pulse", "no pulse");
        end else begin
          v = vin_q.pop_front();
          check("value_in", value_in == 32'(v), $sformatf("%0d", value_in), $sformatf("%0d", v));
        end
        time_out_i[0] = 32'(rsp_s[trk_idx % NRSP]);
        time_out_i[1] = 32'(rsp_e[trk_idx % NRSP]);
        trk_idx++;
      end
    end
  end

  // Monitor: pops the scoreboard on each result handshake.
  initial begin
    exp_t x;
    bit   seen = 1'b0;
    int   first_cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        exp_q.delete();
        seen = 1'b0;
      end else if (res_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first_cyc = cyc;
        end
        if (res_ready) begin
          seen = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1'b0, $sformatf("tag %0d", res_tag), "no result");
          end else begin
            x = exp_q.pop_front();
            check("result",
                  res_start == x.s && res_end == x.e && res_tag == TW'(x.tag) && res_status == 2'(x.st),
                  $sformatf("{%0d,%0d,t%0d,st%0d}", res_start, res_end, res_tag, res_status),
                  $sformatf("{%0d,%0d,t%0d,st%0d}", x.s, x.e, x.tag, x.st));
            if (x.lat >= 0)
              check("latency", first_cyc - x.acc == x.lat,
                    $sformatf("%0d", first_cyc - x.acc), $sformatf("%0d", x.lat));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, n, w;
    for (int i = 0; i < NRSP; i++) begin
      rsp_s[i] = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 200)) : -1;
      rsp_e[i] = ($urandom_range(0, 9) < 5) ? int'($urandom_range(0, 200)) : -1;
    end
    rst = 1'b0; req_valid = 1'b0; req_window = 32'd0; req_tag = 4'd0; rr_mode = 1;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset_state");
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset_state");

    // Single resolved query.
    set_rsp(0, 10, 12);
    c0 = trk_count;
    push(3, 1, 1'b1);
    drain("drain_single");
    check("single_pulses", trk_count - c0 == 1, $sformatf("%0d", trk_count - c0), "1");

    // Out-of-range windows never touch the tracker.
    c0 = trk_count;
    push(9, 2, 1'b1);  drain("drain_bad9");
    push(0, 3, 1'b1);  drain("drain_bad0");
    push(-5, 4, 1'b1); drain("drain_badneg");
    check("badwin_no_pulse", trk_count == c0, $sformatf("%0d", trk_count - c0), "0");

    // Missing end twice, then found: window grows 3,4,5.
    set_rsp(0, 10, -1); set_rsp(1, 10, -1); set_rsp(2, 10, 14);
    push(3, 5, 1'b1);
    drain("drain_grow");

    // Never found: 7 pulses then TIMEOUT.
    for (int k = 0; k <= MAXR; k++) set_rsp(k, -1, -1);
    c0 = trk_count;
    push(5, 6, 1'b1);
    drain("drain_timeout");
    check("timeout_pulses", trk_count - c0 == MAXR + 1, $sformatf("%0d", trk_count - c0), "7");

    // End never found: window saturates at BW, then PARTIAL.
    for (int k = 0; k <= MAXR; k++) set_rsp(k, 5, -1);
    push(3, 7, 1'b1);
    drain("drain_partial");

    // Edge windows 1 and BW are legal.
    set_rsp(0, 1, 2); push(1, 8, 1'b1); drain("drain_w1");
    set_rsp(0, 3, 4); push(BW, 9, 1'b1); drain("drain_wmax");

    // Backpressure: one query in flight plus DEP queued fills the FIFO.
    rr_mode = 0;
    @(negedge clk);
    for (int i = 0; i < DEP + 1; i++) begin
      check("req_ready_open", req_ready == 1'b1, $sformatf("%b", req_ready), "1");
      req_valid = 1'b1; req_window = 32'd2; req_tag = TW'(10 + i);
      predict(2, 10 + i, 1'b0, cyc + 1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("req_ready_full", req_ready == 1'b0, $sformatf("%b", req_ready), "0");
    repeat (5) @(negedge clk);
    check("req_ready_held", req_ready == 1'b0, $sformatf("%b", req_ready), "0");
    rr_mode = 1;
    drain("drain_backpressure");

    // Random traffic with random consumer stalls.
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 11);
      w = (n == 11) ? -2 : n;
      push(w, int'($urandom_range(0, 15)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rr_mode = 1;
    drain("drain_random");

    // Reset while the first query waits on the tracker and two are queued.
    for (int k = 0; k <= MAXR; k++) set_rsp(k, -1, -1);
    push(3, 1, 1'b0);
    push(4, 2, 1'b0);
    push(5, 3, 1'b0);
    n = 0;
    while (!recalculate_time && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("retry_pulse_seen", recalculate_time == 1'b1, $sformatf("%b", recalculate_time), "1");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("mid_query_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      check("no_result_after_reset", res_valid == 1'b0 && recalculate_time == 1'b0 && req_ready == 1'b1,
            $sformatf("rv=%b rc=%b rdy=%b", res_valid, recalculate_time, req_ready), "rv=0 rc=0 rdy=1");
    end
    set_rsp(0, 7, 9);
    push(2, 12, 1'b1);
    drain("drain_after_reset");
    check("pulses_consumed", vin_q.size() == 0, $sformatf("%0d", vin_q.size()), "0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
